keypad_scan_encoder: RTL
========================

// Module: keypad_scan_encoder
// PURPOSE
//  Input-side counterpart of the multiplexed 7-segment display driver. Scans a 4x4 matrix keypad
//  by driving one column low at a time and reading the rows. Debounces the reading and emits
//  one key event per press. Maintains a 4-digit BCD entry register that is returned to the
//  display path and used to set the clock.
// PARAMETERS
//  SCAN_PERIOD     2500  qzt_clk cycles each column stays driven (10 kHz column rate)
//  DEBOUNCE_SCANS  4     consecutive identical full frames needed to accept press/release
//  REPEAT_FRAMES   50    frames between repeats while held (used only with autorepeat)
// PORTS
//  qzt_clk          in   1   system clock
//  reset_sincro     in   1   synchronous, active-high reset
//  row_in           in   4   keypad rows, active-low, asynchronous (pulled up)
//  col_drive        out  4   column drive, active-low one-hot
//  key_code         out  4   last accepted key, = row*4 + col
//  key_valid        out  1   one-cycle strobe, key_code updated same cycle
//  key_held         out  1   high while accepted key remains pressed
//  fourDigitOutput  out  16  BCD entry register, digit3 in [15:12] .. digit0 in [3:0]
// BEHAVIOUR
//  Reset values (next edge after reset_sincro=1, any state)
//  - col_drive=4'b1110, key_code=0, key_valid=0, key_held=0, fourDigitOutput=0
//  - Counters, synchronizer and FSM cleared; FSM returns to IDLE.
//  Input sampling
//  - row_in passes through a 2-flop synchronizer.
//  - Rows are sampled on the last cycle of each column period (cnt==SCAN_PERIOD-1).
//  Scanning
//  - col index 0..3 wraps 3->0.
//  - One frame = 4 column periods.
//  - The frame-end event is the sample of column 3.
//  Frame result
//  - Exactly one row/col low in the frame: result = valid code.
//  - Zero keys, or more than one key (ghosting): result = NONE.
//  FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. Transitions are evaluated at frame end only.
//  - IDLE: result!=NONE -> PRESS_DB, cand=result, dbcnt=1.
//  - PRESS_DB: result==cand -> dbcnt++; when dbcnt reaches DEBOUNCE_SCANS -> HELD,
//    key_code=cand, key_valid=1 for one cycle, key_held=1.
//    result!=cand -> IDLE (a different non-NONE result restarts PRESS_DB with the new cand).
//  - HELD: result==NONE -> RELEASE_DB, dbcnt=1; otherwise stay (a changed key is ignored).
//  - RELEASE_DB: NONE -> dbcnt++; when dbcnt reaches DEBOUNCE_SCANS -> IDLE, key_held=0.
//    Non-NONE -> HELD.
//  - Latency: key_valid is high on the cycle after the frame-end edge that completes debounce.
//  Entry register (updated on the key_valid cycle)
//  - code 0..9: fourDigitOutput <= {fourDigitOutput[11:0], code}; the oldest digit is dropped.
//  - code 10: fourDigitOutput <= 0 (clear).
//  - codes 11..15: register unchanged; still reported on key_code/key_valid.
//  Width rule: dbcnt and repeat counter saturate and never wrap.
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined:
//  - In HELD, after REPEAT_FRAMES frames, key_valid pulses again with the same key_code.
//  - The entry register applies that key again.
//  - The repeat counter restarts after each pulse and clears on leaving HELD.
//  KEYPAD_AUTOREPEAT_EN undefined:
//  - Exactly one key_valid per press, no repeat logic synthesized.
//  - REPEAT_FRAMES is ignored.
// TESTING (bench uses SCAN_PERIOD=4, DEBOUNCE_SCANS=2, REPEAT_FRAMES=3)
//  1 Reset, no keys -> col_drive cycles 1110,1101,1011,0111 every 4 clk; key_valid never high.
//  2 Press row1/col2 stable for 3 frames -> one key_valid, key_code=6,
//    fourDigitOutput=16'h0006, key_held=1.
//  3 Keys 1,2,3,4,5 pressed/released in turn -> fourDigitOutput=16'h2345.
//    Then key 10 -> 16'h0000.
//  4 Press bouncing (present one frame, absent next) -> no key_valid.
//    Two keys in the same frame -> no key_valid.
//  5 reset_sincro pulsed during HELD -> next edge all outputs at reset values.
//    Key still held -> re-accepted after 2 full frames.
//  6 With KEYPAD_AUTOREPEAT_EN, hold key 7 for 12 frames -> initial pulse, then a pulse every
//    3 frames; without it -> exactly one pulse.

Source files
------------

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner with frame-level debounce, key event strobe and 4-digit BCD entry register.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds key autorepeat while a key stays held.
module keypad_scan_encoder #(
    parameter int SCAN_PERIOD    = 2500,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_FRAMES  = 50
) (
    input  logic        qzt_clk,
    input  logic        reset_sincro,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_drive,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] fourDigitOutput
);

    localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    logic [3:0]       row_meta_reg;
    logic [3:0]       row_sync_reg;
    logic [3:0]       row_low;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       col_reg;
    logic [1:0]       col_next;
    logic [3:0]       col_drive_next;
    logic [1:0]       frame_hits_reg;
    logic [3:0]       frame_code_reg;

    logic             sample_now;
    logic             frame_end;
    logic [1:0]       col_hits;
    logic [1:0]       col_row;
    logic [1:0]       base_hits;
    logic [3:0]       base_code;
    logic [2:0]       hit_sum;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_code;
    logic             result_valid;
    logic [3:0]       result_code;

    state_t           state_reg;
    logic [3:0]       cand_reg;
    logic [DB_W-1:0]  dbcnt_reg;
    logic [DB_W-1:0]  dbcnt_inc;

    assign sample_now = (cnt_reg == CNT_LAST);
    assign frame_end  = sample_now && (col_reg == 2'd3);
    assign col_next   = col_reg + 2'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign row_low[gi]        = ~row_sync_reg[gi];
            assign col_drive_next[gi] = (col_next != 2'(gi));
        end
    endgenerate

    // Count low rows in the current column; any count above one already means ghosting.
    always_comb begin
        col_hits = 2'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) begin
                col_row = 2'(r);
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
            end
        end
    end

    always_comb begin
        base_hits    = (col_reg == 2'd0) ? 2'd0 : frame_hits_reg;
        base_code    = (col_reg == 2'd0) ? 4'd0 : frame_code_reg;
        hit_sum      = {1'b0, base_hits} + {1'b0, col_hits};
        acc_hits     = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        acc_code     = (col_hits != 2'd0) ? {col_row, col_reg} : base_code;
        result_valid = (acc_hits == 2'd1);
        result_code  = acc_code;
    end

    assign dbcnt_inc = (dbcnt_reg == DB_TARGET) ? dbcnt_reg : dbcnt_reg + DB_ONE;

    function automatic logic [15:0] apply_key(input logic [15:0] digits, input logic [3:0] code);
        if (code <= 4'd9) begin
            return {digits[11:0], code};
        end else if (code == 4'd10) begin
            return 16'h0000;
        end
        return digits;
    endfunction

    always_ff @(posedge qzt_clk) begin
        if (reset_sincro) begin
            row_meta_reg   <= 4'hF;
            row_sync_reg   <= 4'hF;
            cnt_reg        <= '0;
            col_reg        <= 2'd0;
            col_drive      <= 4'b1110;
            frame_hits_reg <= 2'd0;
            frame_code_reg <= 4'd0;
        end else begin
            row_meta_reg <= row_in;
            row_sync_reg <= row_meta_reg;
            if (sample_now) begin
                cnt_reg        <= '0;
                col_reg        <= col_next;
                col_drive      <= col_drive_next;
                frame_hits_reg <= acc_hits;
                frame_code_reg <= acc_code;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(((REPEAT_FRAMES > 1) ? REPEAT_FRAMES : 1) + 1);
    localparam logic [RPT_W-1:0] RPT_TARGET = RPT_W'((REPEAT_FRAMES > 1) ? REPEAT_FRAMES : 1);
    logic [RPT_W-1:0] rpt_reg;
    logic [RPT_W-1:0] rpt_inc;
    assign rpt_inc = (rpt_reg == RPT_TARGET) ? rpt_reg : rpt_reg + RPT_W'(1);
`endif

    always_ff @(posedge qzt_clk) begin
        if (reset_sincro) begin
            state_reg       <= IDLE;
            cand_reg        <= 4'd0;
            dbcnt_reg       <= '0;
            key_code        <= 4'd0;
            key_valid       <= 1'b0;
            key_held        <= 1'b0;
            fourDigitOutput <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_reg         <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state_reg)
                    IDLE: begin
                        if (result_valid) begin
                            cand_reg  <= result_code;
                            dbcnt_reg <= DB_ONE;
                            if (DB_ONE >= DB_TARGET) begin
                                state_reg       <= HELD;
                                key_code        <= result_code;
                                key_valid       <= 1'b1;
                                key_held        <= 1'b1;
                                fourDigitOutput <= apply_key(fourDigitOutput, result_code);
                            end else begin
                                state_reg <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (result_valid && (result_code == cand_reg)) begin
                            dbcnt_reg <= dbcnt_inc;
                            if (dbcnt_inc >= DB_TARGET) begin
                                state_reg       <= HELD;
                                key_code        <= cand_reg;
                                key_valid       <= 1'b1;
                                key_held        <= 1'b1;
                                fourDigitOutput <= apply_key(fourDigitOutput, cand_reg);
                            end
                        end else if (result_valid) begin
                            // A different key restarts the debounce with the new candidate.
                            cand_reg  <= result_code;
                            dbcnt_reg <= DB_ONE;
                        end else begin
                            state_reg <= IDLE;
                            dbcnt_reg <= '0;
                        end
                    end
                    HELD: begin
                        if (!result_valid) begin
                            dbcnt_reg <= DB_ONE;
                            if (DB_ONE >= DB_TARGET) begin
                                state_reg <= IDLE;
                                key_held  <= 1'b0;
                            end else begin
                                state_reg <= RELEASE_DB;
                            end
`ifdef KEYPAD_AUTOREPEAT_EN
                            rpt_reg <= '0;
                        end else if (rpt_inc >= RPT_TARGET) begin
                            rpt_reg         <= '0;
                            key_valid       <= 1'b1;
                            fourDigitOutput <= apply_key(fourDigitOutput, key_code);
                        end else begin
                            rpt_reg <= rpt_inc;
`endif
                        end
                    end
                    RELEASE_DB: begin
                        if (!result_valid) begin
                            dbcnt_reg <= dbcnt_inc;
                            if (dbcnt_inc >= DB_TARGET) begin
                                state_reg <= IDLE;
                                key_held  <= 1'b0;
                                dbcnt_reg <= '0;
                            end
                        end else begin
                            state_reg <= HELD;
                            dbcnt_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
